mic_ping_pong_writer: RTL
=========================

Name: mic_ping_pong_writer

Overview:
- Parametrised multi-channel sample writer that packs mic-array samples into the on-chip RAM block through its 32-bit s2 slave port.
- The RAM is split into two halves, A and B, used as a ping-pong pair. The Nios reads a completed half over the other port while the next half fills.
- Per-half full flags and a software ack give a lossless handoff. A saturating drop counter records samples lost to overrun.

Parameters:
- NUM_CH, 4, number of mic channels per sample vector (1..16).
- SAMPLE_W, 24, bits per channel sample (8..32). Sign-extended to 32 bits on write.
- ADDR_W, 10, RAM word-address width.
- FRAME_SAMPLES, 64, sample vectors per half.
- Constraint: NUM_CH*FRAME_SAMPLES <= 2**(ADDR_W-1). Violation is an elaboration error.

Ports:
- clk_clk  in  1  single system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- smp_valid  in  1  one-cycle strobe: smp_data holds a new sample vector.
- smp_data  in  NUM_CH*SAMPLE_W  channel 0 in LSBs.
- ram_address  out  ADDR_W  s2 word address.
- ram_chipselect  out  1  s2 chipselect.
- ram_clken  out  1  s2 clock enable.
- ram_write  out  1  s2 write strobe.
- ram_writedata  out  32  s2 write data.
- ram_byteenable  out  4  s2 byte enables.
- half_full  out  2  bit h set when half h holds a complete frame.
- half_ack  in  2  one-cycle pulse per bit: software releases half h.
- fill_half  out  1  half currently being filled.
- busy  out  1  high while a sample vector is being serialised.
- drop_count  out  16  saturating count of dropped sample vectors.

Behaviour:
- Reset values: ram_* = 0; ram_byteenable = 4'h0; half_full = 0; fill_half = 0; busy = 0; drop_count = 0; internal sample index = 0; channel index = 0; FSM = IDLE.
- HALF = NUM_CH*FRAME_SAMPLES. Base address of half h = h*HALF.
- Word address = base + smp_idx*NUM_CH + ch. Channel-interleaved, sample-major.
- FSM state IDLE:
  - On smp_valid with half_full[fill_half] = 0: capture smp_data into a shadow register, go to WRITE, set busy.
  - On smp_valid with half_full[fill_half] = 1: drop the vector, drop_count++ (saturate at 16'hFFFF), stay in IDLE.
- FSM state WRITE:
  - One word per cycle: ram_chipselect = ram_clken = ram_write = 1, ram_byteenable = 4'hF.
  - ram_writedata = sign-extended shadow[ch].
  - ch counts 0..NUM_CH-1. After ch = NUM_CH-1, go to COMMIT.
- Latency: vector accepted at cycle T → channel k written at cycle T+1+k. Outputs are registered.
- smp_valid arriving in WRITE or COMMIT: the vector is dropped, drop_count++. Samples are never queued and the source is never stalled.
- FSM state COMMIT (one cycle):
  - ram strobes = 0, busy = 0.
  - If smp_idx = FRAME_SAMPLES-1: set half_full[fill_half], toggle fill_half, smp_idx = 0.
  - Otherwise smp_idx++.
  - Return to IDLE.
- Outside WRITE: ram_chipselect, ram_clken, ram_write = 0; address and data hold their last value.
- Ack rules:
  - half_ack[h] clears half_full[h] on the next edge.
  - Ack of a half not full is ignored.
  - Ack and set of the same half in the same cycle: set wins.
- Wrap-around: after half 1 completes, fill_half returns to 0 and base returns to 0.
- Boundary case: fill_half points at a full half (software late with the ack) → every arriving vector is dropped until the ack. Filling then restarts at smp_idx 0 of that half; no partial frame is written.
- Reset mid-WRITE: all state clears immediately and asynchronously. The partial vector and partial frame are abandoned. RAM contents are untouched.

Decomposition:
- Shared package mic_pkg holds:
  - FSM enum: IDLE, WRITE, COMMIT.
  - RAM_DATA_W = 32 and RAM_BE_ALL = 4'hF.
  - Sign-extend function sext32(SAMPLE_W).
  - DROP_CNT_W = 16.
- One sub-module is natural: mic_sat_counter, a parametrised-width saturating incrementer with async active-high reset, used for drop_count.

Test Plan (NUM_CH=4, SAMPLE_W=24, FRAME_SAMPLES=2, ADDR_W=5):
1. Single vector {24'h000004, 24'h800003, 24'h000002, 24'h000001} at T → writes at T+1..T+4, addresses 0..3, data 32'h00000001, 32'h00000002, 32'hFF800003, 32'h00000004, byteenable 4'hF.
2. Two vectors spaced 10 cycles apart → addresses 0..7 written; half_full = 2'b01 one cycle after the last write; fill_half = 1.
3. Four vectors, no ack → half_full = 2'b11. A fifth vector → no RAM write, drop_count = 1. half_ack = 2'b01, then a sixth vector → written at address 0.
4. smp_valid on T and T+2 → second vector dropped; drop_count = 1; only 4 writes occur.
5. half_ack[0] in the same cycle half 0 becomes full → half_full[0] stays 1.
6. Assert reset_reset during the third write of a vector → all ram_* strobes drop immediately. After release, the next vector writes at address 0; drop_count = 0.

Source files
------------

// File: rtl/mic_pkg.sv
// mic_pkg: shared FSM states, RAM port constants and sign-extension helper
package mic_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;
   localparam int RAM_DATA_W = 32;
   localparam logic [3:0] RAM_BE_ALL = 4'hF;
   localparam int DROP_CNT_W = 16;
   function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
      logic [31:0] t;
      t = v << (32 - w);
      return 32'($signed(t) >>> (32 - w));
   endfunction
endpackage

// File: rtl/mic_sat_counter.sv
// mic_sat_counter: saturating up-counter with async active-high reset
module mic_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/mic_ping_pong_writer.sv
// mic_ping_pong_writer: serialises mic sample vectors into a ping-pong RAM with lossless half handoff
module mic_ping_pong_writer
   import mic_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int SAMPLE_W      = 24,
   parameter int ADDR_W        = 10,
   parameter int FRAME_SAMPLES = 64
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset,
   input  logic                       smp_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0] smp_data,
   output logic [ADDR_W-1:0]          ram_address,
   output logic                       ram_chipselect,
   output logic                       ram_clken,
   output logic                       ram_write,
   output logic [RAM_DATA_W-1:0]      ram_writedata,
   output logic [3:0]                 ram_byteenable,
   output logic [1:0]                 half_full,
   input  logic [1:0]                 half_ack,
   output logic                       fill_half,
   output logic                       busy,
   output logic [DROP_CNT_W-1:0]      drop_count
);
   localparam int HALF  = NUM_CH * FRAME_SAMPLES;
   localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = FRAME_SAMPLES > 1 ? $clog2(FRAME_SAMPLES) : 1;
   localparam logic [ADDR_W-1:0] HALF_A = ADDR_W'(HALF);
   if (HALF > 2 ** (ADDR_W - 1)) begin : g_size_check
      $error("NUM_CH*FRAME_SAMPLES exceeds half of the RAM address space");
   end
   state_t                     state;
   logic [NUM_CH*SAMPLE_W-1:0] shadow;
   logic [CH_W-1:0]            ch;
   logic [CH_W-1:0]            nch;
   logic [IDX_W-1:0]           smp_idx;
   logic [ADDR_W-1:0]          base_addr;
   logic                       drop;
   assign nch       = ch + 1'b1;
   assign base_addr = (fill_half ? HALF_A : '0) + ADDR_W'(smp_idx) * ADDR_W'(NUM_CH);
   assign drop      = smp_valid && (state != IDLE || half_full[fill_half]);
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         state          <= IDLE;
         shadow         <= '0;
         ch             <= '0;
         smp_idx        <= '0;
         fill_half      <= 1'b0;
         half_full      <= '0;
         busy           <= 1'b0;
         ram_address    <= '0;
         ram_chipselect <= 1'b0;
         ram_clken      <= 1'b0;
         ram_write      <= 1'b0;
         ram_writedata  <= '0;
         ram_byteenable <= 4'h0;
      end else begin
         half_full <= half_full & ~half_ack;
         case (state)
            IDLE:
               if (smp_valid && !half_full[fill_half]) begin
                  state          <= WRITE;
                  shadow         <= smp_data;
                  ch             <= '0;
                  busy           <= 1'b1;
                  ram_chipselect <= 1'b1;
                  ram_clken      <= 1'b1;
                  ram_write      <= 1'b1;
                  ram_byteenable <= RAM_BE_ALL;
                  ram_address    <= base_addr;
                  ram_writedata  <= sext32(32'(smp_data[SAMPLE_W-1:0]), SAMPLE_W);
               end
            WRITE:
               if (ch == CH_W'(NUM_CH - 1)) begin
                  state          <= COMMIT;
                  busy           <= 1'b0;
                  ram_chipselect <= 1'b0;
                  ram_clken      <= 1'b0;
                  ram_write      <= 1'b0;
               end else begin
                  ch            <= nch;
                  ram_address   <= ram_address + 1'b1;
                  ram_writedata <= sext32(32'(shadow[nch*SAMPLE_W +: SAMPLE_W]), SAMPLE_W);
               end
            COMMIT: begin
               state <= IDLE;
               // completing a frame sets its flag even if an ack arrives on the same edge
               if (smp_idx == IDX_W'(FRAME_SAMPLES - 1)) begin
                  half_full <= (half_full & ~half_ack) | (2'b01 << fill_half);
                  fill_half <= ~fill_half;
                  smp_idx   <= '0;
               end else smp_idx <= smp_idx + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   mic_sat_counter #(.W(DROP_CNT_W)) u_drop (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .inc  (drop),
      .count(drop_count)
   );
endmodule
